scan_decoder: RTL

- Parametrised, registered successor to the basic 2-to-4 enable decoder.
- Drives a one-hot output bus of NUM_OUT lines. The active line is chosen either by a manually loaded index or by an internal auto-scan sequencer with programmable dwell time.
- Used for digit/row strobing (7-seg multiplexing, keypad scanning) and as the one-hot select source for downstream mux blocks.

---
 rtl/scan_decoder_pkg.sv | 19 +
 rtl/scan_decoder_onehot_dec.sv | 23 ++
 rtl/scan_decoder.sv | 111 +++++++++++
 3 files changed

// File: rtl/scan_decoder_pkg.sv
// Shared definitions for the scan_decoder block: mode constants, FSM state
// encoding and the output polarity helper.
package scan_decoder_pkg;

   localparam logic MODE_MAN  = 1'b0;
   localparam logic MODE_SCAN = 1'b1;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_MAN  = 2'd1,
      ST_SCAN = 2'd2
   } state_t;

   // Level of a line that is not selected.
   function automatic logic inactive_level(input logic active_low);
      return active_low;
   endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational index to one-hot (or one-cold) decoder; generalised form of
// the original 2-to-4 enable decoder.
module onehot_dec
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W      = 2,
   parameter int NUM_OUT    = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic [SEL_W-1:0]   sel,
   output logic [NUM_OUT-1:0] dec
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUT; gi++) begin : g_line
         localparam logic [SEL_W-1:0] LINE_IDX = SEL_W'(gi);
         assign dec[gi] = (sel == LINE_IDX) ? ~inactive_level(ACTIVE_LOW)
                                            : inactive_level(ACTIVE_LOW);
      end
   endgenerate

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot line driver with manual index load and an auto-scan
// sequencer with programmable dwell time.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int  NUM_OUT    = 4,
   parameter int  DWELL      = 4,
   parameter bit  ACTIVE_LOW = 1'b0,
   localparam int SEL_W      = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               E,
   input  logic               mode,
   input  logic               load,
   input  logic [SEL_W-1:0]   A,
   output logic [NUM_OUT-1:0] D,
   output logic [SEL_W-1:0]   idx,
   output logic               wrap,
   output logic               err
);

   localparam int                 CNT_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SEL_W-1:0]   LAST_IDX    = SEL_W'(NUM_OUT - 1);
   localparam logic [CNT_W-1:0]   LAST_CNT    = CNT_W'(DWELL - 1);
   localparam logic [SEL_W:0]     NUM_OUT_EXT = (SEL_W + 1)'(NUM_OUT);
   localparam logic [NUM_OUT-1:0] D_IDLE      = {NUM_OUT{inactive_level(ACTIVE_LOW)}};

   state_t             state_reg, state_next;
   logic [SEL_W-1:0]   idx_reg, idx_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [NUM_OUT-1:0] d_reg, d_next, dec_next;
   logic               wrap_reg, wrap_next;
   logic               err_reg, err_next;
   logic               a_valid;

   assign a_valid = ({1'b0, A} < NUM_OUT_EXT);

   // Decode the next-state index so D lines up with idx in the same cycle.
   onehot_dec #(
      .SEL_W     (SEL_W),
      .NUM_OUT   (NUM_OUT),
      .ACTIVE_LOW(ACTIVE_LOW)
   ) u_dec (
      .sel(idx_next),
      .dec(dec_next)
   );

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      cnt_next   = cnt_reg;
      wrap_next  = 1'b0;
      err_next   = 1'b0;
      d_next     = D_IDLE;
      if (!E) begin
         state_next = ST_OFF;
      end else if (mode == MODE_SCAN) begin
         state_next = ST_SCAN;
         d_next     = dec_next;
         if (state_reg == ST_MAN) begin
            cnt_next = '0;
         end else if (state_reg == ST_SCAN) begin
            // Entry from OFF shows the held line first; counting starts next edge.
            if (cnt_reg == LAST_CNT) begin
               cnt_next = '0;
               if (idx_reg == LAST_IDX) begin
                  idx_next  = '0;
                  wrap_next = 1'b1;
               end else begin
                  idx_next = idx_reg + SEL_W'(1);
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
      end else begin
         state_next = ST_MAN;
         d_next     = dec_next;
         // Leaving SCAN on this edge takes priority over a coincident load.
         if (state_reg != ST_SCAN && load) begin
            if (a_valid) idx_next = A;
            else         err_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_OFF;
         idx_reg   <= '0;
         cnt_reg   <= '0;
         d_reg     <= D_IDLE;
         wrap_reg  <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         cnt_reg   <= cnt_next;
         d_reg     <= d_next;
         wrap_reg  <= wrap_next;
         err_reg   <= err_next;
      end
   end

   assign D    = d_reg;
   assign idx  = idx_reg;
   assign wrap = wrap_reg;
   assign err  = err_reg;

endmodule
